uart_cmd_decoder: RTL

Frame decoder on the receive end of the UART link. Consumes the byte stream the UART receiver delivers (parallel byte plus one-cycle valid) and turns command frames into one-cycle register-file write/read strobes and ALU-enable strobes for the system-control domain. Supports four frame types, discards bad bytes, and aborts stalled frames with an inter-byte timeout.

---
 rtl/uart_cmd_decoder_if.sv | 30 +++
 rtl/uart_cmd_decoder.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/uart_cmd_decoder_if.sv
// Byte stream from the UART receiver in, register-file / ALU control strobes out.
// The decoder takes the slave side; the UART side (or a bench) takes the master side.
interface uart_cmd_decoder_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned FUN_WIDTH  = 4
);
    logic [DATA_WIDTH-1:0] RX_P_DATA;
    logic                  RX_D_VLD;
    logic                  RX_ERR;
    logic                  WrEn;
    logic                  RdEn;
    logic [ADDR_WIDTH-1:0] Address;
    logic [DATA_WIDTH-1:0] WrData;
    logic                  ALU_EN;
    logic [FUN_WIDTH-1:0]  ALU_FUN;
    logic                  FRAME_BUSY;
    logic                  CMD_ERR;
    logic                  FRM_ERR;

    modport master (
        output RX_P_DATA, RX_D_VLD, RX_ERR,
        input  WrEn, RdEn, Address, WrData, ALU_EN, ALU_FUN, FRAME_BUSY, CMD_ERR, FRM_ERR
    );

    modport slave (
        input  RX_P_DATA, RX_D_VLD, RX_ERR,
        output WrEn, RdEn, Address, WrData, ALU_EN, ALU_FUN, FRAME_BUSY, CMD_ERR, FRM_ERR
    );
endinterface

// File: rtl/uart_cmd_decoder.sv
// Turns UART command frames (write / read / ALU with operands / ALU only) into one-cycle
// register-file and ALU strobes; bad bytes abort a frame, as does an inter-byte timeout.
module uart_cmd_decoder #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned FUN_WIDTH  = 4,
    parameter int unsigned TIMEOUT    = 1024
) (
    input  logic                 CLK,
    input  logic                 RST,
    uart_cmd_decoder_if.slave    bus
);
    localparam int unsigned         CntWidth = $clog2(TIMEOUT + 1);
    localparam logic [CntWidth-1:0] CntLast  = CntWidth'(TIMEOUT - 1);
    localparam logic [DATA_WIDTH-1:0] CmdWrite  = DATA_WIDTH'(8'hAA);
    localparam logic [DATA_WIDTH-1:0] CmdRead   = DATA_WIDTH'(8'hBB);
    localparam logic [DATA_WIDTH-1:0] CmdAluOp  = DATA_WIDTH'(8'hCC);
    localparam logic [DATA_WIDTH-1:0] CmdAluFun = DATA_WIDTH'(8'hDD);

    typedef enum logic [2:0] {
        StIdle, StWrAddr, StWrData, StRdAddr, StAluOpa, StAluOpb, StAluFun, StFunOnly
    } state_e;

    state_e                state_q, state_d;
    logic [CntWidth-1:0]   cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_lat_q, addr_lat_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [FUN_WIDTH-1:0]  fun_q, fun_d;
    logic                  wr_en_q, wr_en_d, rd_en_q, rd_en_d, alu_en_q, alu_en_d;
    logic                  cmd_err_q, cmd_err_d, frm_err_q, frm_err_d, busy_q, busy_d;

    logic [DATA_WIDTH-1:0] rx_data;
    assign rx_data = bus.RX_P_DATA;

    always_comb begin
        state_d    = state_q;
        addr_lat_d = addr_lat_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        fun_d      = fun_q;
        wr_en_d    = 1'b0;
        rd_en_d    = 1'b0;
        alu_en_d   = 1'b0;
        cmd_err_d  = 1'b0;
        frm_err_d  = 1'b0;
        cnt_d      = (state_q == StIdle || bus.RX_D_VLD) ? '0 : cnt_q + CntWidth'(1);

        if (bus.RX_D_VLD && bus.RX_ERR) begin
            // A corrupted byte outside a frame is simply dropped.
            if (state_q != StIdle) begin
                frm_err_d = 1'b1;
                state_d   = StIdle;
            end
        end else if (bus.RX_D_VLD) begin
            unique case (state_q)
                StIdle: begin
                    if (rx_data == CmdWrite)       state_d = StWrAddr;
                    else if (rx_data == CmdRead)   state_d = StRdAddr;
                    else if (rx_data == CmdAluOp)  state_d = StAluOpa;
                    else if (rx_data == CmdAluFun) state_d = StFunOnly;
                    else                           cmd_err_d = 1'b1;
                end
                StWrAddr: begin
                    addr_lat_d = rx_data[ADDR_WIDTH-1:0];
                    state_d    = StWrData;
                end
                StWrData: begin
                    wr_en_d = 1'b1;
                    addr_d  = addr_lat_q;
                    wdata_d = rx_data;
                    state_d = StIdle;
                end
                StRdAddr: begin
                    rd_en_d = 1'b1;
                    addr_d  = rx_data[ADDR_WIDTH-1:0];
                    state_d = StIdle;
                end
                StAluOpa: begin
                    wr_en_d = 1'b1;
                    addr_d  = '0;
                    wdata_d = rx_data;
                    state_d = StAluOpb;
                end
                StAluOpb: begin
                    wr_en_d = 1'b1;
                    addr_d  = ADDR_WIDTH'(1);
                    wdata_d = rx_data;
                    state_d = StAluFun;
                end
                StAluFun, StFunOnly: begin
                    alu_en_d = 1'b1;
                    fun_d    = rx_data[FUN_WIDTH-1:0];
                    state_d  = StIdle;
                end
            endcase
        end else if (state_q != StIdle && cnt_q == CntLast) begin
            frm_err_d = 1'b1;
            state_d   = StIdle;
            cnt_d     = '0;
        end

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            addr_lat_q <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            fun_q      <= '0;
            wr_en_q    <= 1'b0;
            rd_en_q    <= 1'b0;
            alu_en_q   <= 1'b0;
            cmd_err_q  <= 1'b0;
            frm_err_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_lat_q <= addr_lat_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            fun_q      <= fun_d;
            wr_en_q    <= wr_en_d;
            rd_en_q    <= rd_en_d;
            alu_en_q   <= alu_en_d;
            cmd_err_q  <= cmd_err_d;
            frm_err_q  <= frm_err_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.WrEn       = wr_en_q;
    assign bus.RdEn       = rd_en_q;
    assign bus.Address    = addr_q;
    assign bus.WrData     = wdata_q;
    assign bus.ALU_EN     = alu_en_q;
    assign bus.ALU_FUN    = fun_q;
    assign bus.FRAME_BUSY = busy_q;
    assign bus.CMD_ERR    = cmd_err_q;
    assign bus.FRM_ERR    = frm_err_q;
endmodule
